crane_rigger: RTL
=================

Name: crane_rigger

Overview:
- Ground-side rigger/dispatcher at the other end of the crane controller handshake.
- Accepts lift jobs (target angle) from a host into a small queue and starts the crane with `write_mode`/`mode_in`.
- Watches the crane's `action`/`height`/`mode_out` and answers with timed `hooked`/`unhooked` pulses.
- Retires each job when the crane is back home at angle 0.

Parameters:
- DOWN_TO, 3'd0, crane height at which the load is hooked
- UP_TO, 3'd4, crane height at which the load is released
- START_HEIGHT, 3'd6, crane home height
- HOOK_TIME, 4'd5, cycles between hook position reached and `hooked` pulse
- UNHOOK_TIME, 4'd3, cycles between release position reached and `unhooked` pulse
- QDEPTH, 4, job queue depth (power of 2)
- WD_LIMIT, 8'd200, watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  host offers a job
- job_angle  in  2  requested crane angle
- job_ready  out  1  queue not full
- action_in  in  3  crane action code
- height_in  in  3  crane height
- angle_in  in  2  crane current angle (crane `mode_out`)
- write_mode  out  1  one-cycle start pulse to crane
- mode_in  out  2  target angle to crane, held for the whole job
- hooked  out  1  one-cycle hook-done pulse
- unhooked  out  1  one-cycle release-done pulse
- busy  out  1  job in progress (state not IDLE)
- job_done  out  1  one-cycle pulse on job retirement
- jobs_done  out  8  retired-job counter, wraps 255->0
- queue_level  out  3  queue occupancy, 0..QDEPTH
- fault  out  1  sticky watchdog fault (optional feature)
- fault_clr  in  1  clears fault, returns FSM to IDLE (optional feature)

Behaviour:
- All outputs registered. Reset values: 0 for `write_mode`, `mode_in`, `hooked`, `unhooked`, `busy`, `job_done`, `jobs_done`, `queue_level`, `fault`. `job_ready`=1. Queue empty, FSM IDLE, timer 0.
- Queue: push when `job_valid && job_ready`. Pop only in DONE. Push and pop in the same cycle keep the level unchanged. Push while full is ignored. Read/write pointers wrap modulo QDEPTH.
- Crane idle condition (CI): `action_in` ∈ {NOTHING=110, R2=101} and `angle_in`==0 and `height_in`==START_HEIGHT.
- IDLE: if queue not empty and CI, latch head angle into `mode_in` and go to ISSUE.
- ISSUE: `write_mode`=1 for exactly this one cycle. Next state is WAIT_A1.
- WAIT_A1: when `action_in`==A1(001) and `height_in`==DOWN_TO, clear the timer and go to HOOK.
- HOOK: count to HOOK_TIME, then `hooked`=1 for one cycle and go to WAIT_A2. Latency from A1 seen to `hooked` high is HOOK_TIME+1 cycles.
- WAIT_A2: when `action_in`==A2(011) and `height_in`==UP_TO, clear the timer and go to UNHOOK.
- UNHOOK: count to UNHOOK_TIME, then `unhooked`=1 for one cycle and go to WAIT_HOME.
- WAIT_HOME: when `action_in`==R2 and `angle_in`==0, go to DONE.
- DONE: pop the queue, `job_done`=1, increment `jobs_done`, go to IDLE.
- Back-to-back jobs: the next ISSUE cannot occur earlier than 2 cycles after DONE.
- `mode_in` is constant from ISSUE through DONE. Host pushes never disturb it.
- Angle 0 job: the crane goes straight to lowering. The sequence is identical.
- Unknown or other action codes in any WAIT state: keep waiting.
- Reset mid-job: everything is cleared, including queued jobs. Outstanding pulses are dropped.

Optional Feature:
- Macro: CRANE_RIGGER_WATCHDOG_EN.
- Enabled:
  - An 8-bit counter runs in WAIT_A1, WAIT_A2 and WAIT_HOME, and clears on every state change.
  - Reaching WD_LIMIT sets `fault`=1 and moves the FSM to FAULT. No outputs pulse in FAULT.
  - `fault_clr` clears `fault`, drops the head job (pop, no `job_done`) and goes to IDLE.
- Disabled: `fault` tied 0, `fault_clr` ignored, FAULT state absent, WAIT states wait forever.

Decomposition:
- Package `crane_pkg` holds:
  - action code localparams DN=000, A1=001, UP=010, A2=011, R1=100, R2=101, NOTHING=110;
  - the rigger state enum (IDLE, ISSUE, WAIT_A1, HOOK, WAIT_A2, UNHOOK, WAIT_HOME, DONE, FAULT).
- One sub-module, `crane_job_fifo`: synchronous FIFO, width 2, depth QDEPTH, with level output.
- The FSM and timers stay in `crane_rigger`.

Test Plan:
- Reset then push angle 2 while the crane model is idle → `write_mode` pulse 2 cycles after the push. `mode_in`=2 is held until `job_done`.
- Model shows A1 at height 0 → `hooked` high exactly HOOK_TIME+1=6 cycles later, for 1 cycle. A2 at height 4 → `unhooked` 4 cycles later.
- Push 4 jobs (angles 1,3,0,2) at once → `job_ready` drops at level 4. A 5th push is ignored. All four are issued in order and `jobs_done`=4.
- Angle-0 job with a full crane controller model in the loop → completes, `job_done`=1, `angle_in` back to 0.
- Assert reset during HOOK → `hooked` never pulses. `queue_level`=0, `busy`=0.
- With CRANE_RIGGER_WATCHDOG_EN and the crane model stuck (never A1) → `fault`=1 at WD_LIMIT. `fault_clr` → IDLE, `queue_level` decremented, `jobs_done` unchanged.

Source files
------------

// File: rtl/crane_pkg.sv
// Shared definitions for the crane rigger: crane action codes and the rigger FSM states.
package crane_pkg;

    localparam logic [2:0] DN      = 3'b000;
    localparam logic [2:0] A1      = 3'b001;
    localparam logic [2:0] UP      = 3'b010;
    localparam logic [2:0] A2      = 3'b011;
    localparam logic [2:0] R1      = 3'b100;
    localparam logic [2:0] R2      = 3'b101;
    localparam logic [2:0] NOTHING = 3'b110;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ISSUE     = 4'd1,
        WAIT_A1   = 4'd2,
        HOOK      = 4'd3,
        WAIT_A2   = 4'd4,
        UNHOOK    = 4'd5,
        WAIT_HOME = 4'd6,
        DONE      = 4'd7,
        FAULT     = 4'd8
    } rig_state_e;

    function automatic logic is_known_action(input logic [2:0] code);
        return (code == DN) || (code == A1) || (code == UP) || (code == A2) ||
               (code == R1) || (code == R2) || (code == NOTHING);
    endfunction

endpackage

// File: rtl/crane_job_fifo.sv
// Small synchronous job FIFO with registered occupancy and a registered not-full flag.
module crane_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     ready_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push_i && ready_q;
    assign do_pop_s  = pop_i && (count_q != (PW+1)'(0));

    always_comb begin
        wr_ptr_d = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - (PW+1)'(1);
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != (PW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= (PW+1)'(0);
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage is not reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == (PW+1)'(0));
    assign ready_o = ready_q;
    assign level_o = count_q;

endmodule

// File: rtl/crane_rigger.sv
// Ground-side rigger: queues lift jobs, starts the crane and answers hook/release positions
// with timed pulses. Define CRANE_RIGGER_WATCHDOG_EN to add the wait-state watchdog and FAULT.
module crane_rigger
    import crane_pkg::*;
#(
    parameter logic [2:0] DOWN_TO      = 3'd0,
    parameter logic [2:0] UP_TO        = 3'd4,
    parameter logic [2:0] START_HEIGHT = 3'd6,
    parameter logic [3:0] HOOK_TIME    = 4'd5,
    parameter logic [3:0] UNHOOK_TIME  = 4'd3,
    parameter int         QDEPTH       = 4,
    parameter logic [7:0] WD_LIMIT     = 8'd200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      job_valid,
    input  logic [1:0]                job_angle,
    output logic                      job_ready,
    input  logic [2:0]                action_in,
    input  logic [2:0]                height_in,
    input  logic [1:0]                angle_in,
    output logic                      write_mode,
    output logic [1:0]                mode_in,
    output logic                      hooked,
    output logic                      unhooked,
    output logic                      busy,
    output logic                      job_done,
    output logic [7:0]                jobs_done,
    output logic [$clog2(QDEPTH):0]   queue_level,
    output logic                      fault,
    input  logic                      fault_clr
);
    rig_state_e  state_q, state_d;
    logic [3:0]  timer_q, timer_d;
    logic [1:0]  mode_q, mode_d;
    logic        write_mode_q, hooked_q, unhooked_q, busy_q, job_done_q;
    logic [7:0]  jobs_done_q, jobs_done_d;
    logic        pop_s, fifo_empty_s, crane_idle_s;
    logic [1:0]  head_s;

    crane_job_fifo #(.DEPTH(QDEPTH), .WIDTH(2)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (job_valid),
        .pop_i   (pop_s),
        .data_i  (job_angle),
        .data_o  (head_s),
        .empty_o (fifo_empty_s),
        .ready_o (job_ready),
        .level_o (queue_level)
    );

    assign crane_idle_s = ((action_in == NOTHING) || (action_in == R2)) &&
                          (angle_in == 2'd0) && (height_in == START_HEIGHT);

`ifdef CRANE_RIGGER_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       fault_q, fault_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s && crane_idle_s) begin
                    mode_d  = head_s;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = WAIT_A1;
            WAIT_A1: begin
                if ((action_in == A1) && (height_in == DOWN_TO)) begin
                    timer_d = 4'd0;
                    state_d = HOOK;
                end else begin
                    state_d = WAIT_A1;
                end
            end
            HOOK: begin
                if (timer_q == HOOK_TIME) begin
                    state_d = WAIT_A2;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            WAIT_A2: begin
                if ((action_in == A2) && (height_in == UP_TO)) begin
                    timer_d = 4'd0;
                    state_d = UNHOOK;
                end else begin
                    state_d = WAIT_A2;
                end
            end
            UNHOOK: begin
                if (timer_q == UNHOOK_TIME) begin
                    state_d = WAIT_HOME;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            WAIT_HOME: begin
                if ((action_in == R2) && (angle_in == 2'd0)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_HOME;
                end
            end
            DONE: begin
                pop_s   = 1'b1;
                state_d = IDLE;
            end
`ifdef CRANE_RIGGER_WATCHDOG_EN
            FAULT: begin
                if (fault_clr) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FAULT;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef CRANE_RIGGER_WATCHDOG_EN
        // A real state change always wins over a watchdog expiry in the same cycle.
        wd_d    = 8'd0;
        fault_d = fault_q;
        if (((state_q == WAIT_A1) || (state_q == WAIT_A2) || (state_q == WAIT_HOME)) &&
            (state_d == state_q)) begin
            if (wd_q == WD_LIMIT - 8'd1) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end else if (state_q == FAULT) begin
            fault_d = !fault_clr;
        end else begin
            wd_d = 8'd0;
        end
`endif
        jobs_done_d = (state_q == DONE) ? jobs_done_q + 8'd1 : jobs_done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 4'd0;
            mode_q       <= 2'd0;
            write_mode_q <= 1'b0;
            hooked_q     <= 1'b0;
            unhooked_q   <= 1'b0;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            jobs_done_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mode_q       <= mode_d;
            write_mode_q <= (state_q == ISSUE);
            hooked_q     <= (state_q == HOOK) && (state_d == WAIT_A2);
            unhooked_q   <= (state_q == UNHOOK) && (state_d == WAIT_HOME);
            busy_q       <= (state_d != IDLE);
            job_done_q   <= (state_q == DONE);
            jobs_done_q  <= jobs_done_d;
        end
    end

`ifdef CRANE_RIGGER_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q    <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic [8:0] wd_unused_s;
    assign wd_unused_s = {fault_clr, WD_LIMIT};
    assign fault       = 1'b0;
`endif

    assign write_mode = write_mode_q;
    assign mode_in    = mode_q;
    assign hooked     = hooked_q;
    assign unhooked   = unhooked_q;
    assign busy       = busy_q;
    assign job_done   = job_done_q;
    assign jobs_done  = jobs_done_q;

endmodule
